rv32i_decode_exec: RTL and testbench

RV32I_DECODE_EXEC -- requirements
Module: rv32i_decode_exec

---
 rtl/rv32i_pkg.sv | 37 +++
 rtl/rv32i_alu.sv | 88 ++++++++
 rtl/rv32i_decode_exec.sv | 168 ++++++++++++++++
 tb/tb_rv32i_decode_exec.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I decode constants: opcodes, ALU operations and writeback selects.
// Imported by the decode/execute top and its execute datapath.
package rv32i_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [31:0] INSN_NOP = 32'h0000_0013;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_e;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2,
        WB_IMM = 2'd3
    } wbsel_e;

endpackage

// File: rtl/rv32i_alu.sv
// Combinational execute datapath: ALU, result steering for control-flow
// instructions, and branch condition evaluation.
module rv32i_alu
    import rv32i_pkg::*;
#(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32
) (
    input  logic [6:0]        opcode_i,
    input  logic [2:0]        funct3_i,
    input  alu_op_e           alusel_i,
    input  logic              immsel_i,
    input  logic [AWIDTH-1:0] pc_i,
    input  logic [DWIDTH-1:0] imm_i,
    input  logic [DWIDTH-1:0] rs1_data_i,
    input  logic [DWIDTH-1:0] rs2_data_i,
    output logic [DWIDTH-1:0] res_o,
    output logic              brtaken_o
);

    logic [DWIDTH-1:0] opA;
    logic [DWIDTH-1:0] opB;
    logic [4:0]        shAmt;
    logic [DWIDTH-1:0] aluRes;
    logic [DWIDTH-1:0] pcTarget;
    logic [DWIDTH-1:0] jalrSum;
    logic              isEq;
    logic              isLt;
    logic              isLtu;

    assign opA      = rs1_data_i;
    assign opB      = immsel_i ? imm_i : rs2_data_i;
    assign shAmt    = opB[4:0];
    assign pcTarget = DWIDTH'(pc_i) + imm_i;
    assign jalrSum  = rs1_data_i + imm_i;

    always_comb begin
        aluRes = '0;
        case (alusel_i)
            ALU_ADD:  aluRes = opA + opB;
            ALU_SUB:  aluRes = opA - opB;
            ALU_SLL:  aluRes = opA << shAmt;
            ALU_SLT:  aluRes[0] = $signed(opA) < $signed(opB);
            ALU_SLTU: aluRes[0] = opA < opB;
            ALU_XOR:  aluRes = opA ^ opB;
            ALU_SRL:  aluRes = opA >> shAmt;
            ALU_SRA:  aluRes = $signed(opA) >>> shAmt;
            ALU_OR:   aluRes = opA | opB;
            ALU_AND:  aluRes = opA & opB;
            default:  aluRes = opA + opB;
        endcase
    end

    // Control-flow targets bypass the ALU; JALR clears bit 0 of its target.
    always_comb begin
        res_o = aluRes;
        case (opcode_i)
            OPC_BRANCH, OPC_JAL, OPC_AUIPC: res_o = pcTarget;
            OPC_JALR:                       res_o = {jalrSum[DWIDTH-1:1], 1'b0};
            OPC_LUI:                        res_o = imm_i;
            default:                        res_o = aluRes;
        endcase
    end

    assign isEq  = rs1_data_i == rs2_data_i;
    assign isLt  = $signed(rs1_data_i) < $signed(rs2_data_i);
    assign isLtu = rs1_data_i < rs2_data_i;

    always_comb begin
        brtaken_o = 1'b0;
        case (opcode_i)
            OPC_JAL, OPC_JALR: brtaken_o = 1'b1;
            OPC_BRANCH: begin
                case (funct3_i)
                    3'b000:  brtaken_o = isEq;
                    3'b001:  brtaken_o = ~isEq;
                    3'b100:  brtaken_o = isLt;
                    3'b101:  brtaken_o = ~isLt;
                    3'b110:  brtaken_o = isLtu;
                    3'b111:  brtaken_o = ~isLtu;
                    default: brtaken_o = 1'b0;
                endcase
            end
            default: brtaken_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/rv32i_decode_exec.sv
// RV32I decode stage: registered (pc, insn) followed by combinational field
// extraction, immediate generation, control decode and execute.
module rv32i_decode_exec
    import rv32i_pkg::*;
#(
    parameter int                AWIDTH   = 32,
    parameter int                DWIDTH   = 32,
    parameter logic [AWIDTH-1:0] RESET_PC = 32'h0100_0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic [31:0]       insn_i,
    input  logic [AWIDTH-1:0] pc_i,
    input  logic [DWIDTH-1:0] rs1_data_i,
    input  logic [DWIDTH-1:0] rs2_data_i,
    output logic [AWIDTH-1:0] pc_o,
    output logic [31:0]       insn_o,
    output logic [6:0]        opcode_o,
    output logic [4:0]        rd_o,
    output logic [4:0]        rs1_o,
    output logic [4:0]        rs2_o,
    output logic [2:0]        funct3_o,
    output logic [6:0]        funct7_o,
    output logic [4:0]        shamt_o,
    output logic [DWIDTH-1:0] imm_o,
    output logic              pcsel_o,
    output logic              immsel_o,
    output logic              regwren_o,
    output logic              rs1sel_o,
    output logic              rs2sel_o,
    output logic              memren_o,
    output logic              memwren_o,
    output logic [1:0]        wbsel_o,
    output logic [3:0]        alusel_o,
    output logic [DWIDTH-1:0] res_o,
    output logic              brtaken_o,
    output logic              redirect_o
);

    logic [AWIDTH-1:0] pc_q, pc_d;
    logic [31:0]       insn_q, insn_d;
    logic [31:0]       imm32;
    wbsel_e            wbSel;
    alu_op_e           aluSel;

    // Flush still captures the fetched PC so the bubble carries a sane address.
    always_comb begin
        pc_d   = pc_q;
        insn_d = insn_q;
        if (flush_i) begin
            pc_d   = pc_i;
            insn_d = INSN_NOP;
        end else if (!stall_i) begin
            pc_d   = pc_i;
            insn_d = insn_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q   <= RESET_PC;
            insn_q <= INSN_NOP;
        end else begin
            pc_q   <= pc_d;
            insn_q <= insn_d;
        end
    end

    assign pc_o     = pc_q;
    assign insn_o   = insn_q;
    assign opcode_o = insn_q[6:0];
    assign rd_o     = insn_q[11:7];
    assign funct3_o = insn_q[14:12];
    assign rs1_o    = insn_q[19:15];
    assign rs2_o    = insn_q[24:20];
    assign shamt_o  = insn_q[24:20];
    assign funct7_o = insn_q[31:25];

    always_comb begin
        imm32 = '0;
        case (insn_q[6:0])
            OPC_OP_IMM, OPC_LOAD, OPC_JALR:
                imm32 = {{20{insn_q[31]}}, insn_q[31:20]};
            OPC_STORE:
                imm32 = {{20{insn_q[31]}}, insn_q[31:25], insn_q[11:7]};
            OPC_BRANCH:
                imm32 = {{19{insn_q[31]}}, insn_q[31], insn_q[7], insn_q[30:25], insn_q[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC:
                imm32 = {insn_q[31:12], 12'b0};
            OPC_JAL:
                imm32 = {{11{insn_q[31]}}, insn_q[31], insn_q[19:12], insn_q[20], insn_q[30:21], 1'b0};
            default:
                imm32 = '0;
        endcase
    end

    assign imm_o = DWIDTH'($signed(imm32));

    always_comb begin
        pcsel_o   = 1'b0;
        immsel_o  = 1'b0;
        regwren_o = 1'b0;
        rs1sel_o  = 1'b0;
        rs2sel_o  = 1'b0;
        memren_o  = 1'b0;
        memwren_o = 1'b0;
        wbSel     = WB_ALU;
        case (insn_q[6:0])
            OPC_OP:     begin regwren_o = 1'b1; rs1sel_o = 1'b1; rs2sel_o = 1'b1; end
            OPC_OP_IMM: begin regwren_o = 1'b1; rs1sel_o = 1'b1; immsel_o = 1'b1; end
            OPC_LOAD: begin
                regwren_o = 1'b1; rs1sel_o = 1'b1; immsel_o = 1'b1;
                memren_o  = 1'b1; wbSel    = WB_MEM;
            end
            OPC_STORE:  begin rs1sel_o = 1'b1; rs2sel_o = 1'b1; immsel_o = 1'b1; memwren_o = 1'b1; end
            OPC_BRANCH: begin pcsel_o = 1'b1; rs1sel_o = 1'b1; rs2sel_o = 1'b1; end
            OPC_JAL:    begin pcsel_o = 1'b1; regwren_o = 1'b1; wbSel = WB_PC4; end
            OPC_JALR: begin
                pcsel_o  = 1'b1; regwren_o = 1'b1; rs1sel_o = 1'b1;
                immsel_o = 1'b1; wbSel     = WB_PC4;
            end
            OPC_LUI:    begin regwren_o = 1'b1; wbSel = WB_IMM; end
            OPC_AUIPC:  begin regwren_o = 1'b1; wbSel = WB_ALU; end
            default:    ;
        endcase
    end

    // funct7[5] selects SUB only for register-register ops, but SRA for both.
    always_comb begin
        aluSel = ALU_ADD;
        if (insn_q[6:0] == OPC_OP || insn_q[6:0] == OPC_OP_IMM) begin
            case (insn_q[14:12])
                3'b000:  aluSel = (insn_q[6:0] == OPC_OP && insn_q[30]) ? ALU_SUB : ALU_ADD;
                3'b001:  aluSel = ALU_SLL;
                3'b010:  aluSel = ALU_SLT;
                3'b011:  aluSel = ALU_SLTU;
                3'b100:  aluSel = ALU_XOR;
                3'b101:  aluSel = insn_q[30] ? ALU_SRA : ALU_SRL;
                3'b110:  aluSel = ALU_OR;
                default: aluSel = ALU_AND;
            endcase
        end
    end

    assign wbsel_o  = wbSel;
    assign alusel_o = aluSel;

    rv32i_alu #(
        .AWIDTH(AWIDTH),
        .DWIDTH(DWIDTH)
    ) uAlu (
        .opcode_i   (insn_q[6:0]),
        .funct3_i   (insn_q[14:12]),
        .alusel_i   (aluSel),
        .immsel_i   (immsel_o),
        .pc_i       (pc_q),
        .imm_i      (imm_o),
        .rs1_data_i (rs1_data_i),
        .rs2_data_i (rs2_data_i),
        .res_o      (res_o),
        .brtaken_o  (brtaken_o)
    );

    assign redirect_o = pcsel_o & brtaken_o;

endmodule

// File: tb/tb_rv32i_decode_exec.sv
// Self-checking bench for rv32i_decode_exec: directed literal checks followed
// by randomized instruction traffic compared against an instruction-level model.
module tb_rv32i_decode_exec;

    localparam logic [31:0] RST_PC = 32'h0100_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk;
    logic        reset;
    logic        stall_i;
    logic        flush_i;
    logic [31:0] insn_i;
    logic [31:0] pc_i;
    logic [31:0] rs1_data_i;
    logic [31:0] rs2_data_i;
    logic [31:0] pc_o;
    logic [31:0] insn_o;
    logic [6:0]  opcode_o;
    logic [4:0]  rd_o;
    logic [4:0]  rs1_o;
    logic [4:0]  rs2_o;
    logic [2:0]  funct3_o;
    logic [6:0]  funct7_o;
    logic [4:0]  shamt_o;
    logic [31:0] imm_o;
    logic        pcsel_o;
    logic        immsel_o;
    logic        regwren_o;
    logic        rs1sel_o;
    logic        rs2sel_o;
    logic        memren_o;
    logic        memwren_o;
    logic [1:0]  wbsel_o;
    logic [3:0]  alusel_o;
    logic [31:0] res_o;
    logic        brtaken_o;
    logic        redirect_o;

    int testCount = 0;
    int failCount = 0;

    rv32i_decode_exec #(
        .AWIDTH(32),
        .DWIDTH(32),
        .RESET_PC(RST_PC)
    ) dut (
        .clk(clk), .reset(reset), .stall_i(stall_i), .flush_i(flush_i),
        .insn_i(insn_i), .pc_i(pc_i), .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
        .pc_o(pc_o), .insn_o(insn_o), .opcode_o(opcode_o), .rd_o(rd_o),
        .rs1_o(rs1_o), .rs2_o(rs2_o), .funct3_o(funct3_o), .funct7_o(funct7_o),
        .shamt_o(shamt_o), .imm_o(imm_o), .pcsel_o(pcsel_o), .immsel_o(immsel_o),
        .regwren_o(regwren_o), .rs1sel_o(rs1sel_o), .rs2sel_o(rs2sel_o),
        .memren_o(memren_o), .memwren_o(memwren_o), .wbsel_o(wbsel_o),
        .alusel_o(alusel_o), .res_o(res_o), .brtaken_o(brtaken_o), .redirect_o(redirect_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] imm;
        logic [31:0] res;
        logic [3:0]  alu;
        logic [1:0]  wb;
        logic        pcsel;
        logic        immsel;
        logic        regwren;
        logic        rs1sel;
        logic        rs2sel;
        logic        memren;
        logic        memwren;
        logic        br;
    } exp_t;

    // Returns {alusel, result} for an integer computation instruction.
    function automatic logic [35:0] intOp(input logic [2:0] f3, input logic alt,
                                          input logic isReg, input logic [31:0] a,
                                          input logic [31:0] y);
        case (f3)
            3'd0:    return (isReg && alt) ? {4'd1, a - y} : {4'd0, a + y};
            3'd1:    return {4'd2, a << y[4:0]};
            3'd2:    return {4'd3, 31'd0, $signed(a) < $signed(y)};
            3'd3:    return {4'd4, 31'd0, a < y};
            3'd4:    return {4'd5, a ^ y};
            3'd5:    return alt ? {4'd7, 32'($signed(a) >>> y[4:0])} : {4'd6, a >> y[4:0]};
            3'd6:    return {4'd8, a | y};
            default: return {4'd9, a & y};
        endcase
    endfunction

    function automatic logic branchCond(input logic [2:0] f3, input logic [31:0] a,
                                        input logic [31:0] b);
        case (f3)
            3'd0:    return a == b;
            3'd1:    return a != b;
            3'd4:    return $signed(a) < $signed(b);
            3'd5:    return $signed(a) >= $signed(b);
            3'd6:    return a < b;
            3'd7:    return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic exp_t model(input logic [31:0] insn, input logic [31:0] pc,
                                   input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        logic [31:0] immI, immS, immB, immU, immJ;
        e    = '0;
        immI = {{20{insn[31]}}, insn[31:20]};
        immS = {{20{insn[31]}}, insn[31:25], insn[11:7]};
        immB = {{20{insn[31]}}, insn[7], insn[30:25], insn[11:8], 1'b0};
        immU = {insn[31:12], 12'b0};
        immJ = {{12{insn[31]}}, insn[19:12], insn[20], insn[30:21], 1'b0};
        case (insn[6:0])
            7'h33: begin
                e.regwren = 1; e.rs1sel = 1; e.rs2sel = 1;
                {e.alu, e.res} = intOp(insn[14:12], insn[30], 1'b1, a, b);
            end
            7'h13: begin
                e.regwren = 1; e.rs1sel = 1; e.immsel = 1; e.imm = immI;
                {e.alu, e.res} = intOp(insn[14:12], insn[30], 1'b0, a, immI);
            end
            7'h03: begin
                e.regwren = 1; e.rs1sel = 1; e.immsel = 1; e.memren = 1; e.wb = 2'd1;
                e.imm = immI; e.res = a + immI;
            end
            7'h23: begin
                e.rs1sel = 1; e.rs2sel = 1; e.immsel = 1; e.memwren = 1;
                e.imm = immS; e.res = a + immS;
            end
            7'h63: begin
                e.pcsel = 1; e.rs1sel = 1; e.rs2sel = 1; e.imm = immB;
                e.res = pc + immB; e.br = branchCond(insn[14:12], a, b);
            end
            7'h6F: begin
                e.pcsel = 1; e.regwren = 1; e.wb = 2'd2; e.imm = immJ;
                e.res = pc + immJ; e.br = 1;
            end
            7'h67: begin
                e.pcsel = 1; e.regwren = 1; e.rs1sel = 1; e.immsel = 1; e.wb = 2'd2;
                e.imm = immI; e.res = (a + immI) & 32'hFFFF_FFFE; e.br = 1;
            end
            7'h37: begin e.regwren = 1; e.wb = 2'd3; e.imm = immU; e.res = immU; end
            7'h17: begin e.regwren = 1; e.imm = immU; e.res = pc + immU; end
            default: e.res = a + b;
        endcase
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (insn_o=0x%08h t=%0t)",
                     name, act, exp, insn_o, $time);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic st, input logic fl,
                                 input logic [31:0] insn, input logic [31:0] pc,
                                 input logic [31:0] r1, input logic [31:0] r2);
        reset = rst; stall_i = st; flush_i = fl;
        insn_i = insn; pc_i = pc; rs1_data_i = r1; rs2_data_i = r2;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] randInsn();
        logic [31:0] r;
        logic [6:0]  ops [10];
        ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h00};
        r = $urandom;
        r[6:0] = ops[$urandom_range(0, 9)];
        if (r[6:0] == 7'h00) r[6:0] = 7'($urandom);
        if ((r[6:0] == 7'h33 || r[6:0] == 7'h13) && $urandom_range(0, 1) == 1)
            r[31:25] = {1'b0, r[30], 5'b0};
        return r;
    endfunction

    // Architectural view of the decode register, advanced on every rising edge.
    logic [31:0] expPc;
    logic [31:0] expInsn;
    logic        modelValid = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            expPc      = RST_PC;
            expInsn    = NOP;
            modelValid = 1'b1;
        end else if (modelValid) begin
            if (flush_i) begin
                expPc   = pc_i;
                expInsn = NOP;
            end else if (!stall_i) begin
                expPc   = pc_i;
                expInsn = insn_i;
            end
        end
    end

    exp_t cmpExp;

    always @(negedge clk) begin
        if (modelValid) begin
            cmpExp = model(expInsn, expPc, rs1_data_i, rs2_data_i);
            checkOutput("pc_o",     pc_o,      expPc);
            checkOutput("insn_o",   insn_o,    expInsn);
            checkOutput("opcode_o", 32'(opcode_o), 32'(expInsn[6:0]));
            checkOutput("rd_o",     32'(rd_o),     32'(expInsn[11:7]));
            checkOutput("rs1_o",    32'(rs1_o),    32'(expInsn[19:15]));
            checkOutput("rs2_o",    32'(rs2_o),    32'(expInsn[24:20]));
            checkOutput("funct3_o", 32'(funct3_o), 32'(expInsn[14:12]));
            checkOutput("funct7_o", 32'(funct7_o), 32'(expInsn[31:25]));
            checkOutput("shamt_o",  32'(shamt_o),  32'(expInsn[24:20]));
            checkOutput("imm_o",    imm_o,     cmpExp.imm);
            checkOutput("res_o",    res_o,     cmpExp.res);
            checkOutput("alusel_o", 32'(alusel_o), 32'(cmpExp.alu));
            checkOutput("wbsel_o",  32'(wbsel_o),  32'(cmpExp.wb));
            checkOutput("ctrl",
                        32'({pcsel_o, immsel_o, regwren_o, rs1sel_o, rs2sel_o, memren_o, memwren_o}),
                        32'({cmpExp.pcsel, cmpExp.immsel, cmpExp.regwren, cmpExp.rs1sel,
                             cmpExp.rs2sel, cmpExp.memren, cmpExp.memwren}));
            checkOutput("brtaken_o",  32'(brtaken_o),  32'(cmpExp.br));
            checkOutput("redirect_o", 32'(redirect_o), 32'(cmpExp.br & cmpExp.pcsel));
        end
    end

    logic [31:0] r1;

    initial begin
        reset = 1'b1; stall_i = 1'b0; flush_i = 1'b0;
        insn_i = '0; pc_i = '0; rs1_data_i = '0; rs2_data_i = '0;

        applyStimulus(1, 0, 0, 32'h0, 32'h0, 0, 0);
        applyStimulus(1, 1, 1, 32'h00500093, 32'h0200_0000, 0, 0);
        checkOutput("rst pc",      pc_o, 32'h0100_0000);
        checkOutput("rst insn",    insn_o, 32'h0000_0013);
        checkOutput("rst ctrl",    32'({regwren_o, rs1sel_o, immsel_o, memren_o, memwren_o, pcsel_o}), 32'b111000);
        checkOutput("rst redir",   32'({brtaken_o, redirect_o}), 32'd0);

        applyStimulus(0, 0, 0, 32'h00500093, 32'h0100_0000, 0, 0);
        checkOutput("addi rd",     32'(rd_o), 32'd1);
        checkOutput("addi imm",    imm_o, 32'd5);
        checkOutput("addi sel",    32'({immsel_o, regwren_o}), 32'b11);
        checkOutput("addi res",    res_o, 32'd5);

        applyStimulus(0, 0, 0, 32'h40208133, 32'h0100_0004, 32'd10, 32'd3);
        checkOutput("sub alusel",  32'(alusel_o), 32'd1);
        checkOutput("sub res",     res_o, 32'd7);
        applyStimulus(0, 1, 0, 32'h00500093, 32'h0100_0008, 32'd3, 32'd10);
        checkOutput("sub neg res", res_o, 32'hFFFF_FFF9);

        applyStimulus(0, 0, 0, 32'h00208463, 32'h0100_0010, 32'd7, 32'd7);
        checkOutput("beq taken",   32'({brtaken_o, redirect_o}), 32'b11);
        checkOutput("beq target",  res_o, 32'h0100_0018);
        applyStimulus(0, 1, 0, 32'h0, 32'h0, 32'd7, 32'd8);
        checkOutput("beq ntaken",  32'(brtaken_o), 32'd0);

        applyStimulus(0, 0, 0, 32'h123452B7, 32'h0100_0020, 0, 0);
        checkOutput("lui imm",     imm_o, 32'h1234_5000);
        checkOutput("lui wbsel",   32'(wbsel_o), 32'd3);
        checkOutput("lui res",     res_o, 32'h1234_5000);

        applyStimulus(0, 0, 0, 32'h0020A623, 32'h0100_0024, 32'h100, 32'h55);
        checkOutput("sw memwren",  32'(memwren_o), 32'd1);
        checkOutput("sw imm",      imm_o, 32'd12);
        checkOutput("sw res",      res_o, 32'h10C);

        for (int i = 0; i < 2; i++) begin
            applyStimulus(0, 1, 0, 32'h00500093, 32'h0200_0000, 32'h100, 32'h55);
            checkOutput("stall pc",   pc_o, 32'h0100_0024);
            checkOutput("stall insn", insn_o, 32'h0020A623);
        end
        applyStimulus(0, 1, 1, 32'h00500093, 32'h0200_0040, 0, 0);
        checkOutput("flush insn",  insn_o, 32'h0000_0013);
        checkOutput("flush pc",    pc_o, 32'h0200_0040);

        applyStimulus(0, 0, 0, 32'h00208463, 32'h0300_0000, 32'd1, 32'd1);
        applyStimulus(1, 1, 1, 32'h00208463, 32'h0400_0000, 32'd1, 32'd1);
        checkOutput("midrst pc",   pc_o, 32'h0100_0000);
        checkOutput("midrst insn", insn_o, 32'h0000_0013);
        checkOutput("midrst br",   32'({brtaken_o, redirect_o}), 32'd0);

        for (int i = 0; i < 3000; i++) begin
            r1 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            applyStimulus($urandom_range(0, 49) == 0,
                          $urandom_range(0, 4) == 0,
                          $urandom_range(0, 7) == 0,
                          randInsn(), $urandom, r1,
                          ($urandom_range(0, 3) == 0) ? r1 : $urandom);
        end

        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
